// File: rtl/id_ex_decoder.sv
// rtl/id_ex_decoder.sv - ID/EX stage: one-cycle instruction decode register with load-use stall and bubbles
module id_ex_decoder #(
  parameter int NB_REG    = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_FCODE  = 6,
  parameter int NB_ADDR   = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_REG-1:0]    i_instr,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_ready,
  output logic [NB_OPCODE-1:0] o_ALU_op,
  output logic [NB_FCODE-1:0]  o_funct_code,
  output logic [NB_ADDR-1:0]   o_rs,
  output logic [NB_ADDR-1:0]   o_rt,
  output logic [NB_ADDR-1:0]   o_rd,
  output logic [NB_ADDR-1:0]   o_shamt,
  output logic [NB_REG-1:0]    o_imm,
  output logic                 o_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_illegal
);

  logic [NB_OPCODE-1:0] op;
  logic [NB_FCODE-1:0]  funct;
  logic [NB_ADDR-1:0]   rs_f, rt_f, rd_f, sh_f;

  assign op    = i_instr[NB_REG-1 -: NB_OPCODE];
  assign funct = i_instr[NB_FCODE-1:0];
  assign rs_f  = i_instr[21 +: NB_ADDR];
  assign rt_f  = i_instr[16 +: NB_ADDR];
  assign rd_f  = i_instr[11 +: NB_ADDR];
  assign sh_f  = i_instr[6 +: NB_ADDR];

  logic                 legal;
  logic                 dec_rw, dec_mr, dec_mw, zext;
  logic [NB_ADDR-1:0]   dec_rd;
  logic [NB_REG-1:0]    dec_imm;

  always_comb begin
    legal  = 1'b0;
    dec_rw = 1'b0;
    dec_mr = 1'b0;
    dec_mw = 1'b0;
    zext   = 1'b0;
    dec_rd = rt_f;
    case (op)
      6'h00: begin
        dec_rd = rd_f;
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A: begin
            legal  = 1'b1;
            dec_rw = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h02, 6'h04, 6'h05: legal = 1'b1;
      6'h03: begin
        legal  = 1'b1;
        dec_rw = 1'b1;
        dec_rd = '1;
      end
      6'h08, 6'h0A, 6'h0F: begin
        legal  = 1'b1;
        dec_rw = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        legal  = 1'b1;
        dec_rw = 1'b1;
        zext   = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
        legal  = 1'b1;
        dec_rw = 1'b1;
        dec_mr = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        legal  = 1'b1;
        dec_mw = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Register 0 is hardwired; a write to it is never requested downstream.
    if (dec_rd == '0) dec_rw = 1'b0;
    dec_imm = zext ? {{(NB_REG-16){1'b0}}, i_instr[15:0]}
                   : {{(NB_REG-16){i_instr[15]}}, i_instr[15:0]};
  end

  logic hazard, accept, bubble;

  // Load-use: the held load's destination is a source of the incoming word.
  assign hazard = o_valid && o_mem_read && (o_rt != '0) &&
                  ((o_rt == rs_f) || (o_rt == rt_f));
  assign o_ready = !i_stall && !hazard;
  assign accept  = i_valid && o_ready;
  assign bubble  = !i_reset || i_flush || (!i_stall && !(accept && legal));

  always_ff @(posedge i_clock) begin
    if (bubble) begin
      o_valid      <= 1'b0;
      o_ALU_op     <= '0;
      o_funct_code <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_shamt      <= '0;
      o_imm        <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_illegal    <= i_reset && !i_flush && accept;
    end else if (!i_stall) begin
      o_valid      <= 1'b1;
      o_ALU_op     <= op;
      o_funct_code <= funct;
      o_rs         <= rs_f;
      o_rt         <= rt_f;
      o_rd         <= dec_rd;
      o_shamt      <= sh_f;
      o_imm        <= dec_imm;
      o_reg_write  <= dec_rw;
      o_mem_read   <= dec_mr;
      o_mem_write  <= dec_mw;
      o_illegal    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_decoder.sv
// tb/tb_id_ex_decoder.sv - table-driven scoreboard bench for id_ex_decoder
module tb_id_ex_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, stall, flush;
  logic [31:0] instr;
  logic        rdy;
  logic [5:0]  alu_op, fcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm;
  logic        ov, rw, mr, mw, il;

  id_ex_decoder dut (
    .i_clock(clk), .i_reset(rst_n), .i_instr(instr), .i_valid(valid),
    .i_stall(stall), .i_flush(flush), .o_ready(rdy),
    .o_ALU_op(alu_op), .o_funct_code(fcode), .o_rs(rs), .o_rt(rt),
    .o_rd(rd), .o_shamt(shamt), .o_imm(imm), .o_valid(ov),
    .o_reg_write(rw), .o_mem_read(mr), .o_mem_write(mw), .o_illegal(il)
  );

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        il;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        v;
    out_t        exp;
  } vec_t;

  out_t act;
  assign act = {ov, alu_op, fcode, rs, rt, rd, shamt, imm, rw, mr, mw, il};

  out_t sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   failures = 0;

  function automatic out_t mk(logic v, logic [5:0] op, logic [5:0] fn,
                              logic [4:0] s, logic [4:0] t, logic [4:0] d,
                              logic [4:0] sh, logic [31:0] im,
                              logic w, logic r, logic m, logic i);
    out_t o;
    o.v = v; o.op = op; o.fn = fn; o.rs = s; o.rt = t; o.rd = d;
    o.sh = sh; o.imm = im; o.rw = w; o.mr = r; o.mw = m; o.il = i;
    return o;
  endfunction

  task automatic step(input string name, input logic [31:0] ins,
                      input logic v, input logic st, input logic fl,
                      input logic rn, input out_t exp,
                      input logic chk_rdy, input logic exp_rdy);
    out_t e;
    @(negedge clk);
    instr = ins; valid = v; stall = st; flush = fl; rst_n = rn;
    #1;
    if (chk_rdy) begin
      checks++;
      if (rdy !== exp_rdy) begin
        failures++;
        $display("FAIL %s ready: got %b want %b", name, rdy, exp_rdy);
      end
    end
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s outputs: got %h want %h", name, act, e);
    end
  endtask

  out_t bub, ill, o_add1, o_add2, o_lw2, o_andi;

  initial begin
    bub    = '0;
    ill    = mk(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 1);
    o_add1 = mk(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h00001820, 1, 0, 0, 0);
    o_add2 = mk(1, 6'h00, 6'h20, 5'd2, 5'd2, 5'd3, 5'd0, 32'h00001820, 1, 0, 0, 0);
    o_lw2  = mk(1, 6'h23, 6'h00, 5'd1, 5'd2, 5'd2, 5'd0, 32'h0, 1, 1, 0, 0);
    o_andi = mk(1, 6'h0C, 6'h3F, 5'd1, 5'd5, 5'd5, 5'd31, 32'h0000FFFF, 1, 0, 0, 0);

    vt.push_back('{"add",   32'h00221820, 1'b1, o_add1});
    vt.push_back('{"andi",  32'h3025FFFF, 1'b1, o_andi});
    vt.push_back('{"addi",  32'h2025FFFF, 1'b1,
                   mk(1, 6'h08, 6'h3F, 5'd1, 5'd5, 5'd5, 5'd31, 32'hFFFFFFFF, 1, 0, 0, 0)});
    vt.push_back('{"lw9",   32'h8C290000, 1'b1,
                   mk(1, 6'h23, 6'h00, 5'd1, 5'd9, 5'd9, 5'd0, 32'h0, 1, 1, 0, 0)});
    vt.push_back('{"ori",   32'h3422F0F0, 1'b1,
                   mk(1, 6'h0D, 6'h30, 5'd1, 5'd2, 5'd2, 5'd3, 32'h0000F0F0, 1, 0, 0, 0)});
    vt.push_back('{"jal",   32'h0C000010, 1'b1,
                   mk(1, 6'h03, 6'h10, 5'd0, 5'd0, 5'd31, 5'd0, 32'h00000010, 1, 0, 0, 0)});
    vt.push_back('{"nop",   32'h00000000, 1'b1,
                   mk(1, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0)});
    vt.push_back('{"lui",   32'h3C01ABCD, 1'b1,
                   mk(1, 6'h0F, 6'h0D, 5'd0, 5'd1, 5'd1, 5'd15, 32'hFFFFABCD, 1, 0, 0, 0)});
    vt.push_back('{"ill3f", 32'hFC000000, 1'b1, ill});
    vt.push_back('{"jr",    32'h03E00008, 1'b1, ill});
    vt.push_back('{"beq",   32'h10220003, 1'b1,
                   mk(1, 6'h04, 6'h03, 5'd1, 5'd2, 5'd2, 5'd0, 32'h00000003, 0, 0, 0, 0)});
    vt.push_back('{"sb",    32'hA0430000, 1'b1,
                   mk(1, 6'h28, 6'h00, 5'd2, 5'd3, 5'd3, 5'd0, 32'h0, 0, 0, 1, 0)});
    vt.push_back('{"xori0", 32'h38200005, 1'b1,
                   mk(1, 6'h0E, 6'h05, 5'd1, 5'd0, 5'd0, 5'd0, 32'h00000005, 0, 0, 0, 0)});
    vt.push_back('{"sub",   32'h00853022, 1'b1,
                   mk(1, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 32'h00003022, 1, 0, 0, 0)});
    vt.push_back('{"jalr0", 32'h00200009, 1'b1,
                   mk(1, 6'h00, 6'h09, 5'd1, 5'd0, 5'd0, 5'd0, 32'h00000009, 0, 0, 0, 0)});
    vt.push_back('{"idle",  32'h00221820, 1'b0, bub});

    instr = '0; valid = 0; stall = 0; flush = 0; rst_n = 0;

    // Reset held two cycles while a valid instruction is presented.
    step("rst0", 32'h00221820, 1, 0, 0, 0, bub, 1'b0, 1'b0);
    step("rst1", 32'h00221820, 1, 0, 0, 0, bub, 1'b1, 1'b1);

    foreach (vt[i])
      step(vt[i].name, vt[i].instr, vt[i].v, 0, 0, 1, vt[i].exp, 1'b1, 1'b1);

    // Load-use: one bubble, then the held ADD goes through.
    step("lw",      32'h8C220000, 1, 0, 0, 1, o_lw2,  1'b1, 1'b1);
    step("haz",     32'h00421820, 1, 0, 0, 1, bub,    1'b1, 1'b0);
    step("haz_add", 32'h00421820, 1, 0, 0, 1, o_add2, 1'b1, 1'b1);

    // Stall freezes outputs; flush wins over stall.
    step("pre_st", 32'h00221820, 1, 0, 0, 1, o_add1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      step("stall", 32'h3025FFFF, 1, 1, 0, 1, o_add1, 1'b1, 1'b0);
    step("st_fl",  32'h3025FFFF, 1, 1, 1, 1, bub, 1'b1, 1'b0);
    step("post_fl", 32'h3025FFFF, 0, 0, 0, 1, bub, 1'b1, 1'b1);

    // Flush alone on a valid instruction.
    step("fl_add", 32'h00221820, 1, 0, 0, 1, o_add1, 1'b1, 1'b1);
    step("flush",  32'h3025FFFF, 1, 0, 1, 1, bub,    1'b1, 1'b1);

    // Illegal flag lasts exactly one cycle.
    step("ill",    32'hFC000000, 1, 0, 0, 1, ill, 1'b1, 1'b1);
    step("ill_clr", 32'h00000000, 0, 0, 0, 1, bub, 1'b1, 1'b1);

    // Reset mid-hazard and mid-stall leaves nothing pending.
    step("rh_lw",  32'h8C220000, 1, 0, 0, 1, o_lw2,  1'b1, 1'b1);
    step("rh_rst", 32'h00421820, 1, 0, 0, 0, bub,    1'b1, 1'b0);
    step("rh_add", 32'h00421820, 1, 0, 0, 1, o_add2, 1'b1, 1'b1);
    step("rs_andi", 32'h3025FFFF, 1, 0, 0, 1, o_andi, 1'b1, 1'b1);
    step("rs_rst", 32'h00221820, 1, 1, 0, 0, bub,    1'b1, 1'b0);
    step("rs_idle", 32'h00221820, 0, 0, 0, 1, bub,   1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_decoder.md
ID_EX_DECODER -- requirements
Module: id_ex_decoder

Interface
REQ-001 SHALL have parameter NB_REG, default 32, data/instruction width.
REQ-002 SHALL have parameter NB_OPCODE, default 6, opcode width.
REQ-003 SHALL have parameter NB_FCODE, default 6, function-code width.
REQ-004 SHALL have parameter NB_ADDR, default 5, register-index width.
REQ-005 SHALL have port i_clock  input  1  the only clock; all state changes on its rising edge.
REQ-006 SHALL have port i_reset  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port i_instr  input  NB_REG  instruction word.
REQ-008 SHALL have port i_valid  input  1  i_instr valid.
REQ-009 SHALL have port i_stall  input  1  hold output register.
REQ-010 SHALL have port i_flush  input  1  load bubble.
REQ-011 SHALL have port o_ready  output  1  instruction accepted this cycle if i_valid.
REQ-012 SHALL have ports o_ALU_op and o_funct_code  output  NB_OPCODE/NB_FCODE  registered opcode and funct fields, driving alu_control.
REQ-013 SHALL have ports o_rs, o_rt, o_rd, o_shamt  output  NB_ADDR each  registered fields; o_rd is the write destination.
REQ-014 SHALL have port o_imm  output  NB_REG  extended immediate.
REQ-015 SHALL have ports o_valid, o_reg_write, o_mem_read, o_mem_write, o_illegal  output  1 each.

Function
REQ-016 SHALL register all outputs except o_ready (combinational); decode latency exactly 1 cycle.
REQ-017 SHALL accept an instruction when i_valid && o_ready; o_ready = !i_stall && !hazard.
REQ-018 SHALL define hazard = o_valid && o_mem_read && o_rt!=0 && (o_rt==i_instr[25:21] || o_rt==i_instr[20:16]), i.e. load-use on the instruction held in the output register.
REQ-019 SHALL apply per-cycle priority: reset > i_flush > i_stall > hazard > accept > idle.
REQ-020 SHALL on i_flush, hazard, idle, or illegal instruction load a bubble: all outputs zero except o_illegal.
REQ-021 SHALL on i_stall (no flush) hold every output register unchanged.
REQ-022 SHALL recognise R-type opcode 0x00 with funct 0x00,02,03,04,06,07,09,20-27,2A; opcodes 0x02,03,04,05,08,0A,0C,0D,0E,0F,20-25,28,29,2B; anything else is illegal.
REQ-023 SHALL set o_illegal=1 for exactly the cycle after an illegal instruction is accepted, o_valid=0 that cycle.
REQ-024 SHALL select o_rd: instr[15:11] for R-type, 31 for JAL (0x03), instr[20:16] for other I-types.
REQ-025 SHALL zero-extend imm[15:0] for ANDI/ORI/XORI, sign-extend otherwise; o_shamt = instr[10:6].
REQ-026 SHALL set o_reg_write for R-type (except JALR with rd=0), ADDI, SLTI, ANDI, ORI, XORI, LUI, loads, JAL; o_mem_read for 0x20-0x25; o_mem_write for 0x28, 0x29, 0x2B.
REQ-027 SHALL force o_reg_write=0 when the resolved o_rd is 0.
REQ-028 SHALL, on hazard, insert exactly one bubble; the following cycle the hazard is clear, so the held instruction is accepted.

Reset
REQ-029 SHALL, while i_reset=0 at a clock edge, clear all registered outputs to 0; o_ready=1 after reset with i_stall=0.
REQ-030 SHALL, on reset mid-stall or mid-hazard, discard the held instruction with no pending state.

Verification
REQ-031 Reset: i_reset=0 for 2 cycles -> all outputs 0, o_ready=1.
REQ-032 ADD 0x00221820, i_valid=1 -> next cycle o_valid=1, o_ALU_op=0x00, o_funct_code=0x20, o_rs=1, o_rt=2, o_rd=3, o_reg_write=1.
REQ-033 ANDI 0x3025FFFF -> o_imm=0x0000FFFF, o_rd=5; ADDI 0x2025FFFF -> o_imm=0xFFFFFFFF.
REQ-034 LW 0x8C220000 then ADD 0x00421820 held valid -> o_ready=0 for 1 cycle, 1 bubble (o_valid=0), ADD appears 2 cycles after LW.
REQ-035 i_stall=1 for 3 cycles -> outputs frozen; i_flush=1 with i_stall=1 -> bubble next cycle.
REQ-036 Opcode 0x3F accepted -> o_illegal=1 for 1 cycle, o_valid=0, o_reg_write=0.
